// File: rtl/os_array_ctrl.sv
// Output-stationary systolic array controller.
// Each tile runs CLEAR (1 cycle), FEED (k_len+N-1 steps), DRAIN (N-1 steps) and OUT (N rows).
// While stall is high, FEED/DRAIN progress is frozen. In OUT, each row is held until res_ready.
// Ports: clk/rst (sync, active-high), start/k_len tile request, stall operand backpressure,
//        busy/done status, pe_load_acc/pe_en array control, rd_en/rd_idx/lane_valid operand feed,
//        res_valid/res_ready/res_row result row handshake.
module os_array_ctrl #(
  parameter int ARRAY_N = 4,
  parameter int KLEN_W  = 8,
  localparam int ROW_W  = $clog2(ARRAY_N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KLEN_W-1:0]   k_len,
  input  logic                stall,
  output logic                busy,
  output logic                done,
  output logic                pe_load_acc,
  output logic                pe_en,
  output logic                rd_en,
  output logic [KLEN_W:0]     rd_idx,
  output logic [ARRAY_N-1:0]  lane_valid,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ROW_W-1:0]    res_row
);

  localparam int TW = KLEN_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [KLEN_W-1:0] k_q;
  logic [TW-1:0]     t_q;
  logic [ROW_W-1:0]  dcnt_q;
  logic [ROW_W-1:0]  row_q;
  logic              done_q;

  logic [TW-1:0]     t_last;
  logic              feed_last, drain_last, row_last;

  // The last wavefront is the one where the final operand enters lane N-1.
  // t is one bit wider than k_len, so k_len = max does not wrap.
  assign t_last     = {1'b0, k_q} + TW'(ARRAY_N - 2);
  assign feed_last  = (t_q == t_last);
  assign drain_last = (dcnt_q == ROW_W'(ARRAY_N - 2));
  assign row_last   = (row_q == ROW_W'(ARRAY_N - 1));

  // Skewed injection: lane i carries operand element t-i while it is in [0, k_len).
  always_comb begin
    lane_valid = '0;
    if (state_q == FEED) begin
      for (int i = 0; i < ARRAY_N; i++) begin
        lane_valid[i] = (t_q >= TW'(i)) && ((t_q - TW'(i)) < {1'b0, k_q});
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    busy        = (state_q != IDLE);
    pe_load_acc = (state_q == CLEAR);
    pe_en       = ((state_q == FEED) || (state_q == DRAIN)) && !stall;
    rd_en       = (state_q == FEED) && (|lane_valid) && !stall;
    rd_idx      = t_q;
    res_valid   = (state_q == OUT);
    res_row     = row_q;
    done        = done_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = (k_q != '0) ? FEED : OUT;
      FEED:    if (!stall && feed_last) state_d = DRAIN;
      DRAIN:   if (!stall && drain_last) state_d = OUT;
      OUT:     if (res_ready && row_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      t_q     <= '0;
      dcnt_q  <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == OUT) && res_ready && row_last;
      case (state_q)
        IDLE: begin
          if (start) k_q <= k_len;
          t_q    <= '0;
          dcnt_q <= '0;
          row_q  <= '0;
        end
        FEED:    if (!stall) t_q <= t_q + 1'b1;
        DRAIN:   if (!stall) dcnt_q <= dcnt_q + 1'b1;
        OUT:     if (res_ready) row_q <= row_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_os_array_ctrl.sv
// Randomized scoreboard bench for os_array_ctrl.
// The driver pushes per-tile expectations (wavefront steps, result rows, done with busy length).
// A negedge monitor pops and compares them as the DUT shows pe_en, row handshakes and done.
module tb_os_array_ctrl;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int RW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst, start, stall, res_ready;
  logic [KW-1:0] k_len;
  logic          busy, done, pe_load_acc, pe_en, rd_en, res_valid;
  logic [KW:0]   rd_idx;
  logic [N-1:0]  lane_valid;
  logic [RW-1:0] res_row;

  always #5 clk = ~clk;

  os_array_ctrl #(.ARRAY_N(N), .KLEN_W(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .stall(stall),
    .busy(busy), .done(done), .pe_load_acc(pe_load_acc), .pe_en(pe_en),
    .rd_en(rd_en), .rd_idx(rd_idx), .lane_valid(lane_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row)
  );

  // kind 0: array step (pe_en cycle), 1: result row handshake, 2: done pulse
  typedef struct {
    int kind;
    int lane;
    int val;
    bit chk_idx;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_off = 1'b1;
  int   busy_cnt = 0;
  int   extra_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_lane(input int t, input int k);
    int m = 0;
    for (int i = 0; i < N; i++)
      if (t >= i && t - i < k) m |= (1 << i);
    return m;
  endfunction

  task automatic push_tile(input int k);
    exp_t e;
    if (k != 0) begin
      for (int t = 0; t <= k + N - 2; t++) begin
        e.kind = 0; e.lane = model_lane(t, k); e.val = t; e.chk_idx = 1'b1;
        sbq.push_back(e);
      end
      for (int d = 0; d < N - 1; d++) begin
        e.kind = 0; e.lane = 0; e.val = 0; e.chk_idx = 1'b0;
        sbq.push_back(e);
      end
    end
    for (int r = 0; r < N; r++) begin
      e.kind = 1; e.lane = 0; e.val = r; e.chk_idx = 1'b0;
      sbq.push_back(e);
    end
    e.kind = 2; e.lane = 0; e.chk_idx = 1'b0;
    e.val = (k != 0) ? 1 + (k + N - 1) + (N - 1) + N : 1 + N;
    sbq.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!mon_off) begin
      chk("pe_exclusive", int'(pe_en && pe_load_acc), 0);
      chk("stall_gate", int'(stall && (pe_en || rd_en)), 0);
      if (!busy)
        chk("idle_quiet", int'(pe_en || rd_en || pe_load_acc || res_valid || (lane_valid != '0)), 0);
      if (busy) busy_cnt++;
      if (busy && !pe_load_acc && !res_valid && stall) extra_cnt++;
      if (res_valid && !res_ready) extra_cnt++;

      if (pe_en) begin
        if (sbq.size() == 0 || sbq[0].kind != 0) begin
          chk("step_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("lane_valid", int'(lane_valid), e.lane);
          chk("rd_en", int'(rd_en), int'(e.lane != 0));
          if (e.chk_idx) chk("rd_idx", int'(rd_idx), e.val);
        end
      end
      if (res_valid && res_ready) begin
        if (sbq.size() == 0 || sbq[0].kind != 1) begin
          chk("row_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("res_row", int'(res_row), e.val);
        end
      end
      if (done) begin
        if (sbq.size() == 0 || sbq[0].kind != 2) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("busy_cycles", busy_cnt, e.val + extra_cnt);
        end
        busy_cnt  = 0;
        extra_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: no stall, ready high; 1: random stall/ready/stray starts; 2: stall 2 cycles at t=2
  task automatic run_tile(input int k, input int mode);
    bit got = 1'b0;
    int nst = 0;
    push_tile(k);
    start = 1'b1; k_len = KW'(k); stall = 1'b0; res_ready = 1'b1;
    tick();
    start = 1'b0; k_len = KW'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if (mode == 1) begin
        stall     = ($urandom_range(0, 3) == 0);
        res_ready = ($urandom_range(0, 2) != 0);
        start     = busy && !res_valid && ($urandom_range(0, 7) == 0);
        k_len     = KW'($urandom);
      end else if (mode == 2) begin
        stall = 1'b0;
        if (busy && !pe_load_acc && !res_valid && rd_idx == 2 && nst < 2) begin
          stall = 1'b1;
          nst++;
        end
      end
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) chk("done_timeout", 0, 1);
    tick();
    stall = 1'b0; start = 1'b0; res_ready = 1'b1;
  endtask

  task automatic run_abort(input int k, input int n);
    push_tile(k);
    start = 1'b1; k_len = KW'(k); stall = 1'b0; res_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (n) tick();
    mon_off = 1'b1;
    rst = 1'b1;
    start = 1'b1;
    tick();
    @(negedge clk);
    check_quiet("abort");
    sbq.delete();
    busy_cnt = 0;
    extra_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    mon_off = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_load"}, int'(pe_load_acc), 0);
    chk({tag, "_pe_en"}, int'(pe_en), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_lane"}, int'(lane_valid), 0);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_res_row"}, int'(res_row), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; stall = 1'b0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_off = 1'b0;
    tick();

    run_tile(3, 0);
    run_tile(3, 2);
    run_tile(0, 0);
    run_tile(255, 0);
    run_abort(3, 8);
    run_tile(3, 0);
    run_abort(2, 11);
    run_tile(1, 0);
    for (int i = 0; i < 30; i++) begin
      run_tile((i % 7 == 0) ? 0 : $urandom_range(1, 20), 1);
    end
    run_tile(255, 1);

    repeat (5) tick();
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/os_array_ctrl.md
OS_ARRAY_CTRL -- requirements
Module: os_array_ctrl

Interface
REQ-001 The block SHALL have parameter ARRAY_N, default 4, giving the PE array dimension (N x N; N >= 2).
REQ-002 The block SHALL have parameter KLEN_W, default 8, giving the reduction-length width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: tile request, sampled only in IDLE.
REQ-006 The block SHALL have port k_len, input, KLEN_W bits: reduction length, latched on an accepted start.
REQ-007 The block SHALL have port stall, input, 1 bit: operand buffer not ready; while high, FEED/DRAIN progress is frozen.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port pe_load_acc, output, 1 bit: array-wide accumulator load (partial_sum_in tied to 0 externally).
REQ-011 The block SHALL have port pe_en, output, 1 bit: array-wide MAC/shift enable.
REQ-012 The block SHALL have port rd_en, output, 1 bit: operand buffer read strobe.
REQ-013 The block SHALL have port rd_idx, output, KLEN_W+1 bits: operand buffer wavefront index t.
REQ-014 The block SHALL have port lane_valid, output, ARRAY_N bits: per row/column injection mask (0 = inject zero operand).
REQ-015 The block SHALL have port res_valid, output, 1 bit: result row available.
REQ-016 The block SHALL have port res_ready, input, 1 bit: result consumer accepts the row.
REQ-017 The block SHALL have port res_row, output, clog2(ARRAY_N) bits: index of the result row being presented.

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, FEED, DRAIN, OUT; all outputs SHALL be decoded from registered state/counters, except that pe_en and rd_en are additionally gated combinationally by stall.
REQ-019 In IDLE, start=1 SHALL latch k_len and move to CLEAR on the next edge; start SHALL be ignored in all other states.
REQ-020 CLEAR SHALL last exactly 1 cycle with pe_load_acc=1 and pe_en=0, then go to FEED if latched k_len != 0, else to OUT.
REQ-021 FEED SHALL step t from 0 to k_len+N-2 inclusive, one step per non-stalled cycle, with rd_idx = t.
REQ-022 In FEED, lane_valid[i] SHALL be 1 iff t >= i and t-i < k_len.
REQ-023 In FEED, rd_en SHALL equal (|lane_valid) & ~stall and pe_en SHALL equal ~stall; FEED SHALL go to DRAIN after the non-stalled cycle with t = k_len+N-2.
REQ-024 DRAIN SHALL last N-1 non-stalled cycles with pe_en = ~stall, rd_en=0 and lane_valid=0, then go to OUT.
REQ-025 When stall=1, t, the drain count, and the state SHALL hold, and pe_en and rd_en SHALL be 0.
REQ-026 In OUT, res_valid SHALL be 1 and res_row SHALL start at 0; each cycle with res_valid & res_ready SHALL increment res_row.
REQ-027 The handshake on row N-1 SHALL move the FSM to IDLE, and done SHALL be 1 for exactly the following cycle; res_valid SHALL not drop before ready.
REQ-028 pe_en and pe_load_acc SHALL be 0 in IDLE and OUT; pe_load_acc and pe_en SHALL never be 1 in the same cycle.
REQ-029 The t counter SHALL be KLEN_W+1 bits wide so that k_len = 2^KLEN_W-1 does not wrap.
REQ-030 Timing with no stall and res_ready=1 SHALL be: busy for 1 + (k_len+N-1) + (N-1) + N cycles (k_len != 0) or 1 + N cycles (k_len = 0).

Reset
REQ-031 With rst=1 at a clock edge, the FSM SHALL go to IDLE, t, the drain count, and res_row SHALL go to 0, and busy, done, pe_load_acc, pe_en, rd_en, lane_valid and res_valid SHALL be 0 in the following cycle.
REQ-032 Reset SHALL take priority over start, including when asserted mid-FEED or mid-OUT; no done pulse SHALL be produced for an aborted tile.

Verification
REQ-033 N=4, k_len=3, no stall, res_ready=1 -> CLEAR 1 cycle; FEED lane_valid = 0001, 0011, 0111, 1110, 1100, 1000 with rd_idx 0..5; DRAIN 3 cycles; OUT rows 0..3; busy 14 cycles; then done pulse.
REQ-034 Same as REQ-033 with stall=1 for 2 cycles at t=2 -> rd_idx/lane_valid held at t=2, pe_en=rd_en=0 for those 2 cycles, total busy 16 cycles.
REQ-035 k_len=0 start -> CLEAR, then OUT directly (no pe_en cycle), busy 5 cycles, done pulse.
REQ-036 res_ready held low 3 cycles on row 1 -> res_row stays 1 with res_valid=1 throughout; done occurs 3 cycles later than the no-backpressure case.
REQ-037 start pulsed during FEED -> ignored, k_len unchanged; rst asserted mid-DRAIN -> next cycle all outputs 0 and IDLE; a new start is accepted immediately after.
REQ-038 k_len=255 (KLEN_W=8), N=4 -> FEED runs t = 0..257 without wrap and lane_valid=1000 at t=257.
